id_stage: RTL and testbench

Instruction-decode stage, directly downstream of the fetch stage. It consumes PC+4 and the instruction word from fetch, holds them in an internal IF/ID pipeline register, and reads the register file with write-back bypass. It detects load-use and branch-operand hazards, and resolves beq/bne/j/jal in ID. It returns stall and redirect controls to fetch, and presents decoded operands to the ID/EX register.

---
 rtl/id_stage_if.sv | 26 ++
 rtl/id_stage.sv | 159 +++++++++++++++
 tb/tb_id_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-to-decode handshake: instruction in, stall/redirect back
interface id_stage_if;
    logic [31:0] i_next_pc;
    logic [31:0] i_instr;
    logic        o_stall;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;

    // Fetch side drives the instruction stream and obeys stall/redirect
    modport master (
        output i_next_pc,
        output i_instr,
        input  o_stall,
        input  o_redirect,
        input  o_redirect_pc
    );

    // Decode side consumes the instruction stream and issues stall/redirect
    modport slave (
        input  i_next_pc,
        input  i_instr,
        output o_stall,
        output o_redirect,
        output o_redirect_pc
    );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode: IF/ID register, bypassed regfile, hazards, branch resolve
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    id_stage_if.slave   fetch,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_dest,
    input  logic        i_mem_reg_write,
    input  logic [4:0]  i_mem_dest,
    output logic        o_valid,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_imm_ext,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_funct
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        uses_rt;
    logic        is_branch;
    logic        load_use;
    logic        br_haz;
    logic        stall;
    logic        taken;
    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // IF/ID pipeline register: stall holds, redirect flushes to a bubble, else advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end else if (redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else begin
            r_instr <= fetch.i_instr;
            r_pc4   <= fetch.i_next_pc;
            r_valid <= 1'b1;
        end
    end

    // Register file write port; r0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (i_wb_we && (i_wb_addr != 5'd0)) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    assign opcode = r_instr[31:26];
    assign rs     = r_instr[25:21];
    assign rt     = r_instr[20:16];
    assign imm    = r_instr[15:0];

    // Register reads with write-through so a same-cycle write-back is seen
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (rs == 5'd0) begin
            rs_val = 32'd0;
        end else if (i_wb_we && (i_wb_addr == rs)) begin
            rs_val = i_wb_data;
        end
        if (rt == 5'd0) begin
            rt_val = 32'd0;
        end else if (i_wb_we && (i_wb_addr == rt)) begin
            rt_val = i_wb_data;
        end
    end

    // Hazard detection: load-use against EX, branch operands against EX and MEM producers
    always_comb begin
        uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                    (opcode == OP_BNE) || (opcode == OP_SW);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        load_use  = r_valid && i_ex_mem_read && (i_ex_dest != 5'd0) &&
                    ((i_ex_dest == rs) || (uses_rt && (i_ex_dest == rt)));
        br_haz    = r_valid && is_branch &&
                    ((i_ex_reg_write && (i_ex_dest != 5'd0) &&
                      ((i_ex_dest == rs) || (i_ex_dest == rt))) ||
                     (i_mem_reg_write && (i_mem_dest != 5'd0) &&
                      ((i_mem_dest == rs) || (i_mem_dest == rt))));
        stall     = reset && (load_use || br_haz);
    end

    // Branch/jump resolution; a stalled branch waits for its operands before redirecting
    always_comb begin
        br_target = r_pc4 + {{14{imm[15]}}, imm, 2'b00};
        j_target  = {r_pc4[31:28], r_instr[25:0], 2'b00};
        taken     = ((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                    ((opcode == OP_BNE) && (rs_val != rt_val)) ||
                    (opcode == OP_J) || (opcode == OP_JAL);
        redirect  = reset && r_valid && !stall && taken;
        fetch.o_redirect_pc = 32'd0;
        if (redirect) begin
            fetch.o_redirect_pc = is_branch ? br_target : j_target;
        end
    end

    // Immediate extension: logical immediates are zero-extended, everything else signed
    always_comb begin
        if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
            o_imm_ext = {16'd0, imm};
        end else begin
            o_imm_ext = {{16{imm[15]}}, imm};
        end
    end

    assign fetch.o_stall    = stall;
    assign fetch.o_redirect = redirect;
    assign o_valid    = r_valid;
    assign o_pc_plus4 = r_pc4;
    assign o_rs_data  = rs_val;
    assign o_rt_data  = rt_val;
    assign o_rs       = rs;
    assign o_rt       = rt;
    assign o_rd       = r_instr[15:11];
    assign o_opcode   = opcode;
    assign o_funct    = r_instr[5:0];
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed vectors
module tb_id_stage;
    localparam int S_VALID = 0;
    localparam int S_PC4   = 1;
    localparam int S_STALL = 2;
    localparam int S_REDIR = 3;
    localparam int S_RPC   = 4;
    localparam int S_RSD   = 5;
    localparam int S_RTD   = 6;
    localparam int S_IMM   = 7;
    localparam int S_OPC   = 8;
    localparam int S_RT    = 9;
    localparam int S_RS    = 10;
    localparam int S_RD    = 11;
    localparam int S_FUNCT = 12;

    logic        clk;
    logic        reset;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_ex_reg_write;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_dest;
    logic        i_mem_reg_write;
    logic [4:0]  i_mem_dest;
    logic        o_valid;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm_ext;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;

    id_stage_if fif ();

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fetch          (fif.slave),
        .i_wb_we        (i_wb_we),
        .i_wb_addr      (i_wb_addr),
        .i_wb_data      (i_wb_data),
        .i_ex_reg_write (i_ex_reg_write),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_ex_dest      (i_ex_dest),
        .i_mem_reg_write(i_mem_reg_write),
        .i_mem_dest     (i_mem_dest),
        .o_valid        (o_valid),
        .o_pc_plus4     (o_pc_plus4),
        .o_rs_data      (o_rs_data),
        .o_rt_data      (o_rt_data),
        .o_imm_ext      (o_imm_ext),
        .o_rs           (o_rs),
        .o_rt           (o_rt),
        .o_rd           (o_rd),
        .o_opcode       (o_opcode),
        .o_funct        (o_funct)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    string       name_q [$];
    int          sig_q  [$];
    logic [31:0] val_q  [$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] get_sig(input int sig);
        case (sig)
            S_VALID: return {31'd0, o_valid};
            S_PC4:   return o_pc_plus4;
            S_STALL: return {31'd0, fif.o_stall};
            S_REDIR: return {31'd0, fif.o_redirect};
            S_RPC:   return fif.o_redirect_pc;
            S_RSD:   return o_rs_data;
            S_RTD:   return o_rt_data;
            S_IMM:   return o_imm_ext;
            S_OPC:   return {26'd0, o_opcode};
            S_RT:    return {27'd0, o_rt};
            S_RS:    return {27'd0, o_rs};
            S_RD:    return {27'd0, o_rd};
            S_FUNCT: return {26'd0, o_funct};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_sig(input string name, input int sig, input logic [31:0] val);
        name_q.push_back(name);
        sig_q.push_back(sig);
        val_q.push_back(val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] instr, input logic [31:0] pc4);
        fif.i_instr   = instr;
        fif.i_next_pc = pc4;
    endtask

    // Monitor: pops pending expectations and compares them on the falling edge
    always @(negedge clk) begin
        while (sig_q.size() > 0) begin
            string       nm;
            int          sg;
            logic [31:0] ex;
            logic [31:0] act;
            nm  = name_q.pop_front();
            sg  = sig_q.pop_front();
            ex  = val_q.pop_front();
            act = get_sig(sg);
            n_cmp++;
            if (act !== ex) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, act, ex);
            end
        end
    end

    initial begin
        reset = 1'b0;
        i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
        i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_ex_dest = 5'd0;
        i_mem_reg_write = 1'b0; i_mem_dest = 5'd0;
        feed(32'h0, 32'h0);

        tick();
        expect_sig("rst_valid", S_VALID, 32'd0);
        expect_sig("rst_pc4", S_PC4, 32'd0);
        expect_sig("rst_stall", S_STALL, 32'd0);
        expect_sig("rst_redir", S_REDIR, 32'd0);

        // release reset, load add r8,r8,r9 with a load into r8 in EX
        tick();
        reset = 1'b1;
        feed(32'h0109_4020, 32'h40);
        tick();
        i_ex_mem_read = 1'b1; i_ex_dest = 5'd8;
        expect_sig("pre_valid", S_VALID, 32'd1);
        expect_sig("pre_pc4", S_PC4, 32'h40);
        expect_sig("pre_rd", S_RD, 32'd8);
        expect_sig("pre_funct", S_FUNCT, 32'h20);
        expect_sig("pre_stall", S_STALL, 32'd1);

        // reset asserted mid-cycle while a stall condition is still present
        tick();
        #2;
        reset = 1'b0;
        expect_sig("mid_rst_valid", S_VALID, 32'd0);
        expect_sig("mid_rst_pc4", S_PC4, 32'd0);
        expect_sig("mid_rst_stall", S_STALL, 32'd0);
        expect_sig("mid_rst_redir", S_REDIR, 32'd0);

        tick();
        reset = 1'b1;
        i_ex_mem_read = 1'b0; i_ex_dest = 5'd0;
        feed(32'h2008_0005, 32'h4);
        tick();
        expect_sig("addi_valid", S_VALID, 32'd1);
        expect_sig("addi_opc", S_OPC, 32'h08);
        expect_sig("addi_rt", S_RT, 32'd8);
        expect_sig("addi_imm", S_IMM, 32'h5);
        expect_sig("addi_pc4", S_PC4, 32'h4);

        // write-back bypass into r9, then r0 write ignored
        feed(32'h0120_4020, 32'h10);
        tick();
        i_wb_we = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'hDEAD_BEEF;
        feed(32'h0009_4020, 32'h14);
        expect_sig("byp_rs", S_RS, 32'd9);
        expect_sig("byp_rsd", S_RSD, 32'hDEAD_BEEF);
        tick();
        i_wb_addr = 5'd0; i_wb_data = 32'h1234_5678;
        feed(32'h0, 32'h18);
        expect_sig("r0_rsd", S_RSD, 32'd0);
        expect_sig("r9_rtd", S_RTD, 32'hDEAD_BEEF);
        tick();
        i_wb_addr = 5'd1; i_wb_data = 32'd7;
        tick();
        i_wb_addr = 5'd2; i_wb_data = 32'd7;
        tick();
        i_wb_addr = 5'd3; i_wb_data = 32'd5;
        tick();
        i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;

        // load-use stall for one cycle
        feed(32'h0100_4020, 32'h50);
        tick();
        i_ex_mem_read = 1'b1; i_ex_dest = 5'd8;
        feed(32'h2009_0001, 32'h54);
        expect_sig("lu_stall", S_STALL, 32'd1);
        expect_sig("lu_pc4", S_PC4, 32'h50);
        tick();
        i_ex_mem_read = 1'b0; i_ex_dest = 5'd0;
        expect_sig("lu_hold_stall", S_STALL, 32'd0);
        expect_sig("lu_hold_pc4", S_PC4, 32'h50);
        expect_sig("lu_hold_valid", S_VALID, 32'd1);
        tick();
        expect_sig("lu_adv_pc4", S_PC4, 32'h54);
        expect_sig("lu_adv_opc", S_OPC, 32'h08);

        // ori ignores rt for load-use; zero-extended immediate
        feed(32'h3408_8000, 32'h60);
        tick();
        i_ex_mem_read = 1'b1; i_ex_dest = 5'd8;
        feed(32'h0, 32'h64);
        expect_sig("ori_stall", S_STALL, 32'd0);
        expect_sig("ori_imm", S_IMM, 32'h0000_8000);
        tick();
        i_ex_mem_read = 1'b0; i_ex_dest = 5'd0;

        // beq r1,r2,-1 taken, then flush
        feed(32'h1022_FFFF, 32'h100);
        tick();
        feed(32'h2009_0001, 32'h104);
        expect_sig("beq_redir", S_REDIR, 32'd1);
        expect_sig("beq_rpc", S_RPC, 32'h0000_00FC);
        tick();
        feed(32'h0, 32'h108);
        expect_sig("beq_flush_valid", S_VALID, 32'd0);
        expect_sig("beq_flush_redir", S_REDIR, 32'd0);
        expect_sig("beq_flush_rpc", S_RPC, 32'd0);
        expect_sig("beq_flush_opc", S_OPC, 32'd0);
        tick();

        // bne r3,r0 with r3 produced in MEM: stall, then redirect
        feed(32'h1460_0004, 32'h200);
        i_mem_reg_write = 1'b1; i_mem_dest = 5'd3;
        tick();
        feed(32'h0, 32'h204);
        expect_sig("bh_stall", S_STALL, 32'd1);
        expect_sig("bh_redir", S_REDIR, 32'd0);
        expect_sig("bh_rpc", S_RPC, 32'd0);
        tick();
        i_mem_reg_write = 1'b0; i_mem_dest = 5'd0;
        expect_sig("bh_clear_stall", S_STALL, 32'd0);
        expect_sig("bh_clear_redir", S_REDIR, 32'd1);
        expect_sig("bh_clear_rpc", S_RPC, 32'h0000_0210);
        expect_sig("bh_clear_pc4", S_PC4, 32'h200);
        tick();
        expect_sig("bh_flush_valid", S_VALID, 32'd0);

        // j with upper PC bits carried into the target
        feed(32'h0800_0040, 32'hA000_0008);
        tick();
        feed(32'h0, 32'hA000_000C);
        expect_sig("j_redir", S_REDIR, 32'd1);
        expect_sig("j_rpc", S_RPC, 32'hA000_0100);
        tick();
        expect_sig("j_flush_valid", S_VALID, 32'd0);

        // beq r0,r0 with most-negative offset wraps below zero
        feed(32'h1000_8000, 32'h4);
        tick();
        feed(32'h0, 32'h8);
        expect_sig("wrap_redir", S_REDIR, 32'd1);
        expect_sig("wrap_rpc", S_RPC, 32'hFFFE_0004);
        tick();
        tick();

        if (sig_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d pending expected 0", sig_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
